// File: rtl/mutex_pkg.sv
`default_nettype none
//-----------------------------------------------------------------------------
// +-------------------------------------------------------------------------+
// | Package    : mutex_pkg                                                  |
// | Purpose    : Shared definitions for mutex / arbiter blocks: the owner   |
// |              state encoding and a constant clog2 helper used to size    |
// |              index and counter fields.                                  |
// | Ports      : none (package)                                             |
// | Revision   : 1.0  initial release                                       |
// +-------------------------------------------------------------------------+
//-----------------------------------------------------------------------------
package mutex_pkg;

   // Owner state encoding
   localparam logic IDLE  = 1'b0;
   localparam logic OWNED = 1'b1;

   typedef enum logic {
      ST_IDLE  = IDLE,
      ST_OWNED = OWNED
   } mutex_state_t;

   // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
//-----------------------------------------------------------------------------
// +-------------------------------------------------------------------------+
// | Module     : rr_pick                                                    |
// | Purpose    : Combinational rotate-priority selector. Returns the first  |
// |              set bit of Eligible searching upward from Pointer and      |
// |              wrapping modulo n.                                         |
// | Ports      : Eligible[n]      candidate requesters                      |
// |              Pointer[IW]      index searched first                      |
// |              Found            any eligible bit set                      |
// |              WinnerIndex[IW]  binary index of the winner (0 if none)    |
// |              WinnerOneHot[n]  one-hot winner (0 if none)                |
// | Revision   : 1.0  initial release                                       |
// +-------------------------------------------------------------------------+
//-----------------------------------------------------------------------------
module rr_pick
   import mutex_pkg::*;
#(
   parameter  int n  = 4,
   localparam int IW = (n > 1) ? clog2(n) : 1
) (
   input  logic [n-1:0]  Eligible,
   input  logic [IW-1:0] Pointer,
   output logic          Found,
   output logic [IW-1:0] WinnerIndex,
   output logic [n-1:0]  WinnerOneHot
);

   int            w_idx;
   logic [IW-1:0] w_sel;

   // Walk the n candidates starting at Pointer; the first hit wins and later
   // hits are masked by Found.
   always_comb begin
      Found        = 1'b0;
      WinnerIndex  = '0;
      WinnerOneHot = '0;
      w_idx        = 0;
      w_sel        = '0;
      for (int k = 0; k < n; k++) begin
         w_idx = int'(Pointer) + k;
         if (w_idx >= n) begin
            w_idx = w_idx - n;
         end
         w_sel = IW'(w_idx);
         if (!Found && Eligible[w_sel]) begin
            Found               = 1'b1;
            WinnerIndex         = w_sel;
            WinnerOneHot[w_sel] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/round_robin_mutex.sv
`default_nettype none
//-----------------------------------------------------------------------------
// +-------------------------------------------------------------------------+
// | Module     : round_robin_mutex                                          |
// | Purpose    : Round-robin mutex sharing one resource among n requesters, |
// |              with an optional maximum contested-hold watchdog.          |
// | Ports      : nReset            async active-low reset                   |
// |              Clk               rising-edge clock                        |
// |              Request[n]        per-requester request, held for access   |
// |              Grant[n]          registered one-hot grant, 0 when idle    |
// |              GrantIndex[IW]    index of current or last owner           |
// |              Busy              any Grant bit high                       |
// |              Revoked           1-cycle pulse when watchdog revokes      |
// |              RevokedIndex[IW]  index of the revoked requester           |
// | Revision   : 1.0  initial release                                       |
// +-------------------------------------------------------------------------+
//-----------------------------------------------------------------------------
module round_robin_mutex
   import mutex_pkg::*;
#(
   parameter  int n       = 4,
   parameter  int MaxHold = 256,
   localparam int IW      = (n > 1) ? clog2(n) : 1
) (
   input  logic          nReset,
   input  logic          Clk,
   input  logic [n-1:0]  Request,
   output logic [n-1:0]  Grant,
   output logic [IW-1:0] GrantIndex,
   output logic          Busy,
   output logic          Revoked,
   output logic [IW-1:0] RevokedIndex
);

   localparam int              c_hold_w      = (clog2(MaxHold + 1) > 0) ? clog2(MaxHold + 1) : 1;
   localparam logic [c_hold_w-1:0] c_hold_limit  = c_hold_w'(MaxHold);
   localparam logic [c_hold_w-1:0] c_hold_thresh = c_hold_w'((MaxHold > 0) ? (MaxHold - 1) : 0);
   localparam logic            c_watchdog_en = (MaxHold > 0);
   localparam logic [IW-1:0]   c_last_index  = IW'(n - 1);

   mutex_state_t        r_state;
   mutex_state_t        w_state_next;
   logic [n-1:0]        r_grant;
   logic [n-1:0]        w_grant_next;
   logic [IW-1:0]       r_grant_index;
   logic [IW-1:0]       w_grant_index_next;
   logic                r_busy;
   logic                w_busy_next;
   logic                r_revoked;
   logic                w_revoked_next;
   logic [IW-1:0]       r_revoked_index;
   logic [IW-1:0]       w_revoked_index_next;
   logic [IW-1:0]       r_pointer;
   logic [IW-1:0]       w_pointer_next;
   logic [n-1:0]        r_blocked;
   logic [n-1:0]        w_blocked_next;
   logic [c_hold_w-1:0] r_hold;
   logic [c_hold_w-1:0] w_hold_next;

   logic [n-1:0]        w_eligible;
   logic                w_owner_req;
   logic                w_contested;
   logic                w_timeout;
   logic                w_found;
   logic [IW-1:0]       w_winner_index;
   logic [n-1:0]        w_winner_onehot;

   // A revoked requester stays blocked until it drops its request.
   assign w_eligible  = Request & ~r_blocked;
   // r_grant is one-hot while owned, so masking avoids a variable index.
   assign w_owner_req = |(Request & r_grant);
   assign w_contested = |(w_eligible & ~r_grant);
   assign w_timeout   = c_watchdog_en && (r_hold >= c_hold_thresh);

   rr_pick #(
      .n (n)
   ) u_pick (
      .Eligible     (w_eligible),
      .Pointer      (r_pointer),
      .Found        (w_found),
      .WinnerIndex  (w_winner_index),
      .WinnerOneHot (w_winner_onehot)
   );

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         r_state         <= ST_IDLE;
         r_grant         <= '0;
         r_grant_index   <= '0;
         r_busy          <= 1'b0;
         r_revoked       <= 1'b0;
         r_revoked_index <= '0;
         r_pointer       <= '0;
         r_blocked       <= '0;
         r_hold          <= '0;
      end else begin
         r_state         <= w_state_next;
         r_grant         <= w_grant_next;
         r_grant_index   <= w_grant_index_next;
         r_busy          <= w_busy_next;
         r_revoked       <= w_revoked_next;
         r_revoked_index <= w_revoked_index_next;
         r_pointer       <= w_pointer_next;
         r_blocked       <= w_blocked_next;
         r_hold          <= w_hold_next;
      end
   end

   always_comb begin
      w_state_next         = r_state;
      w_grant_next         = r_grant;
      w_grant_index_next   = r_grant_index;
      w_busy_next          = r_busy;
      w_revoked_next       = 1'b0;
      w_revoked_index_next = r_revoked_index;
      w_pointer_next       = r_pointer;
      w_blocked_next       = r_blocked & Request;
      w_hold_next          = r_hold;

      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_state_next       = ST_OWNED;
               w_grant_next       = w_winner_onehot;
               w_grant_index_next = w_winner_index;
               w_busy_next        = 1'b1;
               w_hold_next        = '0;
               w_pointer_next     = (w_winner_index == c_last_index) ? '0
                                                                      : w_winner_index + 1'b1;
            end
         end

         ST_OWNED: begin
            if (!w_owner_req) begin
               // Release takes precedence over a coincident timeout.
               w_state_next = ST_IDLE;
               w_grant_next = '0;
               w_busy_next  = 1'b0;
            end else if (w_timeout && w_contested) begin
               w_state_next         = ST_IDLE;
               w_grant_next         = '0;
               w_busy_next          = 1'b0;
               w_revoked_next       = 1'b1;
               w_revoked_index_next = r_grant_index;
               w_blocked_next       = (r_blocked & Request) | r_grant;
            end else if (r_hold != c_hold_limit) begin
               w_hold_next = r_hold + 1'b1;
            end
         end

         default: begin
            w_state_next = ST_IDLE;
            w_grant_next = '0;
            w_busy_next  = 1'b0;
         end
      endcase
   end

   assign Grant        = r_grant;
   assign GrantIndex   = r_grant_index;
   assign Busy         = r_busy;
   assign Revoked      = r_revoked;
   assign RevokedIndex = r_revoked_index;

endmodule
`default_nettype wire

// File: tb/tb_round_robin_mutex.sv
`default_nettype none
`timescale 1ns/1ps
//-----------------------------------------------------------------------------
// +-------------------------------------------------------------------------+
// | Module     : tb_round_robin_mutex                                       |
// | Purpose    : Self-checking bench for round_robin_mutex (n=4, MaxHold=8) |
// |              with directed scenarios and random request traffic         |
// |              compared against a behavioural owner/pointer model.        |
// | Revision   : 1.0  initial release                                       |
// +-------------------------------------------------------------------------+
//-----------------------------------------------------------------------------
module tb_round_robin_mutex;

   localparam int N       = 4;
   localparam int MAXHOLD = 8;

   logic         Clk     = 1'b0;
   logic         nReset  = 1'b0;
   logic [N-1:0] Request = '0;
   logic [N-1:0] Grant;
   logic [1:0]   GrantIndex;
   logic         Busy;
   logic         Revoked;
   logic [1:0]   RevokedIndex;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int           m_owner;     // -1 when idle
   int           m_ptr;
   logic [N-1:0] m_blocked;
   int           m_hold;
   int           m_gidx;
   bit           m_revoked;
   int           m_ridx;

   round_robin_mutex #(
      .n       (N),
      .MaxHold (MAXHOLD)
   ) dut (
      .nReset       (nReset),
      .Clk          (Clk),
      .Request      (Request),
      .Grant        (Grant),
      .GrantIndex   (GrantIndex),
      .Busy         (Busy),
      .Revoked      (Revoked),
      .RevokedIndex (RevokedIndex)
   );

   always #5 Clk = ~Clk;

   task automatic check_value(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   task automatic model_reset();
      m_owner   = -1;
      m_ptr     = 0;
      m_blocked = '0;
      m_hold    = 0;
      m_gidx    = 0;
      m_revoked = 0;
      m_ridx    = 0;
   endtask

   // One clock edge of the mutex rules, given the requests sampled there.
   task automatic model_step(input logic [N-1:0] req);
      logic [N-1:0] elig;
      logic [N-1:0] others;
      int           w;
      int           i;
      elig      = req & ~m_blocked;
      m_revoked = 0;
      m_blocked = m_blocked & req;
      if (m_owner < 0) begin
         w = -1;
         for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (w < 0 && elig[i]) w = i;
         end
         if (w >= 0) begin
            m_owner = w;
            m_gidx  = w;
            m_hold  = 0;
            m_ptr   = (w + 1) % N;
         end
      end else begin
         others = elig;
         others[m_owner] = 1'b0;
         if (!req[m_owner]) begin
            m_owner = -1;
         end else if (MAXHOLD > 0 && others != 0 && m_hold >= MAXHOLD - 1) begin
            m_revoked            = 1;
            m_ridx               = m_owner;
            m_blocked[m_owner]   = 1'b1;
            m_owner              = -1;
         end else if (m_hold < MAXHOLD) begin
            m_hold++;
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [31:0] exp_grant;
      exp_grant = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
      check_value({tag, "/grant"},  32'(Grant),        exp_grant);
      check_value({tag, "/gidx"},   32'(GrantIndex),   32'(m_gidx));
      check_value({tag, "/busy"},   32'(Busy),         32'(m_owner >= 0));
      check_value({tag, "/revoked"},32'(Revoked),      32'(m_revoked));
      check_value({tag, "/ridx"},   32'(RevokedIndex), 32'(m_ridx));
   endtask

   task automatic run_cycle(input logic [N-1:0] req, input string tag);
      Request = req;
      @(posedge Clk);
      model_step(req);
      #1;
      check_outputs(tag);
   endtask

   task automatic apply_reset();
      @(negedge Clk);
      nReset  = 1'b0;
      Request = '0;
      @(negedge Clk);
      nReset = 1'b1;
      model_reset();
      #1;
      check_outputs("reset");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      int           grant0_cycles;
      int           revoke_count;
      int           ridx_seen;
      int           age;
      bit           prev_busy;
      int           order[$];
      logic [N-1:0] req;

      model_reset();
      apply_reset();

      // ---- Async reset while a grant is held ----
      run_cycle(4'b0100, "pre_rst");
      run_cycle(4'b0100, "pre_rst");
      check_value("pre_rst_grant", 32'(Grant), 32'h4);
      #2;
      nReset = 1'b0;
      #1;
      check_value("async_rst_grant", 32'(Grant), 32'h0);
      check_value("async_rst_busy",  32'(Busy),  32'h0);
      @(negedge Clk);
      nReset  = 1'b1;
      Request = '0;
      model_reset();
      run_cycle(4'b0000, "post_rst");
      run_cycle(4'b0000, "post_rst");
      check_value("post_rst_grant",   32'(Grant),   32'h0);
      check_value("post_rst_revoked", 32'(Revoked), 32'h0);

      // ---- Single requester ----
      apply_reset();
      run_cycle(4'b0010, "single");
      check_value("single_grant", 32'(Grant),      32'h2);
      check_value("single_gidx",  32'(GrantIndex), 32'h1);
      run_cycle(4'b0010, "single");
      run_cycle(4'b0000, "single_rel");
      check_value("single_rel_grant", 32'(Grant), 32'h0);

      // ---- Fairness: all request, owner releases 3 cycles after grant ----
      apply_reset();
      age = 0;
      prev_busy = 1'b0;
      for (int c = 0; c < 18; c++) begin
         req = 4'hF;
         if (m_owner >= 0 && age == 3) req[m_owner] = 1'b0;
         run_cycle(req, "fair");
         age = (m_owner >= 0) ? age + 1 : 0;
         if (Busy && !prev_busy) order.push_back(int'(GrantIndex));
         prev_busy = Busy;
      end
      check_value("fair_count", 32'(order.size() >= 5), 32'h1);
      if (order.size() >= 5) begin
         check_value("fair_order0", 32'(order[0]), 32'd0);
         check_value("fair_order1", 32'(order[1]), 32'd1);
         check_value("fair_order2", 32'(order[2]), 32'd2);
         check_value("fair_order3", 32'(order[3]), 32'd3);
         check_value("fair_order4", 32'(order[4]), 32'd0);
      end

      // ---- Watchdog revoke ----
      apply_reset();
      grant0_cycles = 0;
      revoke_count  = 0;
      ridx_seen     = -1;
      for (int c = 0; c < 13; c++) begin
         run_cycle((c < 3) ? 4'b0001 : 4'b0101, "wdog");
         if (Grant[0]) grant0_cycles++;
         if (Revoked) begin
            revoke_count++;
            ridx_seen = int'(RevokedIndex);
         end
      end
      check_value("wdog_hold_cycles", 32'(grant0_cycles), 32'd8);
      check_value("wdog_revokes",     32'(revoke_count),  32'd1);
      check_value("wdog_ridx",        32'(ridx_seen),     32'd0);
      check_value("wdog_new_owner",   32'(Grant),         32'h4);
      for (int c = 0; c < 3; c++) run_cycle(4'b0001, "wdog_blocked");
      check_value("wdog_blocked_grant", 32'(Grant), 32'h0);
      run_cycle(4'b0000, "wdog_drop");
      run_cycle(4'b0001, "wdog_rereq");
      run_cycle(4'b0001, "wdog_rereq");
      check_value("wdog_regrant", 32'(Grant), 32'h1);

      // ---- Uncontested hold ----
      apply_reset();
      revoke_count = 0;
      for (int c = 0; c < 50; c++) begin
         run_cycle(4'b1000, "uncont");
         if (Revoked) revoke_count++;
      end
      check_value("uncont_revokes", 32'(revoke_count), 32'd0);
      check_value("uncont_grant",   32'(Grant),        32'h8);
      run_cycle(4'b1010, "uncont_contest");
      check_value("uncont_revoked", 32'(Revoked),      32'h1);
      check_value("uncont_ridx",    32'(RevokedIndex), 32'd3);
      run_cycle(4'b1010, "uncont_next");
      check_value("uncont_next_grant", 32'(Grant), 32'h2);

      // ---- Release coinciding with timeout ----
      apply_reset();
      run_cycle(4'b0001, "simul");
      for (int c = 0; c < 7; c++) run_cycle(4'b0011, "simul");
      run_cycle(4'b0010, "simul_rel");
      check_value("simul_revoked", 32'(Revoked), 32'h0);
      run_cycle(4'b0010, "simul");
      check_value("simul_grant1", 32'(Grant), 32'h2);
      run_cycle(4'b0001, "simul");
      run_cycle(4'b0001, "simul");
      check_value("simul_grant0", 32'(Grant), 32'h1);

      // ---- Random traffic ----
      apply_reset();
      req = '0;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
         end
         run_cycle(req, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
